fifo_rd_ctrl: RTL and testbench

//  Read-side controller of the dual-clock 8-bit FIFO; the counterpart of the write port (wrEn/din/fifoFull).

---
 rtl/fifo_rd_ctrl.sv | 132 +++++++++++++
 tb/tb_fifo_rd_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_rd_ctrl
// Read-side controller of a dual-clock FIFO. Everything here runs on the
// read clock. The block owns the read pointer, brings the write pointer in
// through a Gray-code synchroniser, and derives the empty flag and the word
// count. It also registers read data from the shared dual-port memory.
//
// Ports
//   i_rdClk      read clock, the only clock
//   i_rst        asynchronous active-low reset
//   i_rdEn       read request
//   o_dout       registered read data
//   o_rdValid    o_dout holds the word accepted on the previous edge
//   o_fifoEmpty  registered empty flag
//   o_underflow  one-cycle pulse: read requested while empty
//   o_rdCount    words available (read-domain view, may lag writes)
//   i_wrPtrGray  Gray write pointer from the write domain (asynchronous)
//   o_rdPtrGray  registered Gray read pointer to the write domain
//   o_memRdAddr  memory read address
//   i_memRdData  memory read data (asynchronous read of o_memRdAddr)
// ---------------------------------------------------------------------------
module fifo_rd_ctrl #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_rdClk,
  input  logic              i_rst,
  input  logic              i_rdEn,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_rdValid,
  output logic              o_fifoEmpty,
  output logic              o_underflow,
  output logic [ADDR_W:0]   o_rdCount,
  input  logic [ADDR_W:0]   i_wrPtrGray,
  output logic [ADDR_W:0]   o_rdPtrGray,
  output logic [ADDR_W-1:0] o_memRdAddr,
  input  logic [DATA_W-1:0] i_memRdData
);

  localparam int PTR_W = ADDR_W + 1;

  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PTR_W-1:0]  r_wr_sync [SYNC_STAGES];
  logic [PTR_W-1:0]  r_rd_ptr_bin;
  logic [PTR_W-1:0]  r_rd_ptr_gray;
  logic              r_empty;
  logic [PTR_W-1:0]  r_count;
  logic [DATA_W-1:0] r_dout;
  logic              r_valid;
  logic              r_underflow;

  logic              w_rd_acc;
  logic [PTR_W-1:0]  w_wr_gray_sync;
  logic [PTR_W-1:0]  w_wr_bin_sync;
  logic [PTR_W-1:0]  w_rd_ptr_bin_nxt;
  logic [PTR_W-1:0]  w_rd_ptr_gray_nxt;

  // The registered empty flag gates acceptance; no same-cycle bypass.
  assign w_rd_acc          = i_rdEn & ~r_empty;
  assign w_wr_gray_sync    = r_wr_sync[SYNC_STAGES-1];
  assign w_wr_bin_sync     = gray2bin(w_wr_gray_sync);
  assign w_rd_ptr_bin_nxt  = r_rd_ptr_bin + {{(PTR_W-1){1'b0}}, w_rd_acc};
  assign w_rd_ptr_gray_nxt = bin2gray(w_rd_ptr_bin_nxt);

  // Write-pointer synchroniser. Only Gray values cross, so at most one bit
  // is in flight and a metastable sample resolves to an adjacent pointer.
  always_ff @(posedge i_rdClk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_wr_sync[i] <= '0;
      end
    end else begin
      r_wr_sync[0] <= i_wrPtrGray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_wr_sync[i] <= r_wr_sync[i-1];
      end
    end
  end

  // Pointer and status. Empty and count look at the post-read pointer, so
  // the edge that consumes the last word also raises empty.
  always_ff @(posedge i_rdClk or negedge i_rst) begin
    if (!i_rst) begin
      r_rd_ptr_bin  <= '0;
      r_rd_ptr_gray <= '0;
      r_empty       <= 1'b1;
      r_count       <= '0;
      r_underflow   <= 1'b0;
    end else begin
      r_rd_ptr_bin  <= w_rd_ptr_bin_nxt;
      r_rd_ptr_gray <= w_rd_ptr_gray_nxt;
      r_empty       <= (w_rd_ptr_gray_nxt == w_wr_gray_sync);
      r_count       <= w_wr_bin_sync - w_rd_ptr_bin_nxt;
      r_underflow   <= i_rdEn & r_empty;
    end
  end

  // Read data register: captures only on an accepted read, holds otherwise.
  always_ff @(posedge i_rdClk or negedge i_rst) begin
    if (!i_rst) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_dout <= i_memRdData;
      end
    end
  end

  assign o_dout      = r_dout;
  assign o_rdValid   = r_valid;
  assign o_fifoEmpty = r_empty;
  assign o_underflow = r_underflow;
  assign o_rdCount   = r_count;
  assign o_rdPtrGray = r_rd_ptr_gray;
  assign o_memRdAddr = r_rd_ptr_bin[ADDR_W-1:0];

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
module tb_fifo_rd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rd_en = 1'b0;
  logic [4:0] wr_gray = '0;
  logic [7:0] dout;
  logic       rd_valid, fifo_empty, underflow;
  logic [4:0] rd_count, rd_ptr_gray;
  logic [3:0] mem_rd_addr;
  logic [7:0] mem_rd_data;
  logic [7:0] mem [16];

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  assign mem_rd_data = mem[mem_rd_addr];

  fifo_rd_ctrl #(.DATA_W(8), .ADDR_W(4), .SYNC_STAGES(2)) dut (
    .i_rdClk    (clk),
    .i_rst      (rst_n),
    .i_rdEn     (rd_en),
    .o_dout     (dout),
    .o_rdValid  (rd_valid),
    .o_fifoEmpty(fifo_empty),
    .o_underflow(underflow),
    .o_rdCount  (rd_count),
    .i_wrPtrGray(wr_gray),
    .o_rdPtrGray(rd_ptr_gray),
    .o_memRdAddr(mem_rd_addr),
    .i_memRdData(mem_rd_data)
  );

  function automatic int g2b(input logic [4:0] g);
    int b = 0;
    for (int i = 4; i >= 0; i--) b = (b << 1) | ((b & 1) ^ int'(g[i]));
    return b;
  endfunction

  function automatic logic [4:0] b2g(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: reads and writes as plain word counts modulo 32. A write is seen
  // by the read side two edges after it is sampled.
  int   m_rd, m_p0, m_p1, m_count;
  bit   m_empty, m_valid, m_under, m_acc;
  int   m_dout;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rd = 0; m_p0 = 0; m_p1 = 0; m_count = 0;
      m_empty = 1; m_valid = 0; m_under = 0; m_dout = 0;
    end else begin
      m_acc   = rd_en && !m_empty;
      m_under = rd_en && m_empty;
      m_valid = m_acc;
      if (m_acc) begin
        m_dout = int'(mem[m_rd % 16]);
        m_rd   = (m_rd + 1) % 32;
      end
      m_empty = (m_rd == m_p1);
      m_count = (m_p1 - m_rd + 32) % 32;
      m_p1 = m_p0;
      m_p0 = g2b(wr_gray);
    end
  end

  always @(negedge clk) begin
    chk("dout",      int'(dout),        m_dout);
    chk("rdValid",   int'(rd_valid),    int'(m_valid));
    chk("fifoEmpty", int'(fifo_empty),  int'(m_empty));
    chk("underflow", int'(underflow),   int'(m_under));
    chk("rdCount",   int'(rd_count),    m_count);
    chk("rdPtrGray", int'(rd_ptr_gray), int'(b2g(m_rd)));
    chk("memRdAddr", int'(mem_rd_addr), m_rd % 16);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rd_en = 0;
    wr_gray = '0;
    rst_n = 0;
    step();
    step();
    rst_n = 1;
    step();
  endtask

  int reads, first_c, last_c;
  logic [4:0] prev_g;

  initial begin
    mem[0] = 8'hA5;
    for (int i = 1; i < 16; i++) mem[i] = 8'(8'h30 + i * 11);

    step();
    step();
    rst_n = 1;
    step();

    // Write visibility latency and a single read
    wr_gray = 5'h01;
    step(); step(); step();
    chk("t2_empty", int'(fifo_empty), 0);
    chk("t2_count", int'(rd_count), 1);
    rd_en = 1;
    step();
    rd_en = 0;
    chk("t2_dout",  int'(dout), 8'hA5);
    chk("t2_valid", int'(rd_valid), 1);
    chk("t2_empty_after", int'(fifo_empty), 1);
    chk("t2_gray",  int'(rd_ptr_gray), 5'h01);

    // Underflow
    rd_en = 1;
    step();
    rd_en = 0;
    chk("t3_under", int'(underflow), 1);
    chk("t3_gray",  int'(rd_ptr_gray), 5'h01);
    chk("t3_count", int'(rd_count), 0);
    chk("t3_dout",  int'(dout), 8'hA5);
    chk("t3_valid", int'(rd_valid), 0);
    step();
    chk("t3_under_clr", int'(underflow), 0);

    // Asynchronous reset mid-cycle
    #3;
    rst_n = 0;
    #1;
    chk("t1_empty", int'(fifo_empty), 1);
    chk("t1_valid", int'(rd_valid), 0);
    chk("t1_dout",  int'(dout), 0);
    chk("t1_gray",  int'(rd_ptr_gray), 0);
    chk("t1_count", int'(rd_count), 0);
    wr_gray = '0;
    step();
    rst_n = 1;
    step();

    // Full memory, 16 back-to-back reads
    wr_gray = 5'h18;
    step(); step(); step();
    chk("t4_count", int'(rd_count), 16);
    chk("t4_empty", int'(fifo_empty), 0);
    rd_en = 1;
    for (int k = 0; k < 16; k++) begin
      step();
      chk("t4_valid", int'(rd_valid), 1);
      chk("t4_data",  int'(dout), int'(mem[k]));
    end
    rd_en = 0;
    chk("t4_empty_last", int'(fifo_empty), 1);
    chk("t4_count_last", int'(rd_count), 0);

    // Wrap: 40 streaming writes and reads
    reset_pulse();
    rd_en = 1;
    reads = 0; first_c = -1; last_c = -1;
    prev_g = rd_ptr_gray;
    for (int c = 1; c <= 60; c++) begin
      wr_gray = b2g(((c <= 40) ? c : 40) % 32);
      step();
      if (rd_ptr_gray != prev_g) begin
        reads++;
        chk("t5_gray_1bit", $countones(rd_ptr_gray ^ prev_g), 1);
        if (reads == 1) first_c = c;
        last_c = c;
        if (reads == 15) chk("t5_msb_r15", int'(rd_ptr_gray[4]), 0);
        if (reads == 16) chk("t5_msb_r16", int'(rd_ptr_gray[4]), 1);
        if (reads == 31) chk("t5_msb_r31", int'(rd_ptr_gray[4]), 1);
        if (reads == 32) chk("t5_msb_r32", int'(rd_ptr_gray[4]), 0);
        prev_g = rd_ptr_gray;
      end
    end
    rd_en = 0;
    chk("t5_reads", reads, 40);
    chk("t5_no_bubble", last_c - first_c, 39);

    // Reset mid-burst
    reset_pulse();
    wr_gray = b2g(8);
    step(); step(); step();
    rd_en = 1;
    step(); step(); step();
    chk("t6_gray_pre", int'(rd_ptr_gray), int'(b2g(3)));
    #3;
    rst_n = 0;
    #1;
    chk("t6_empty", int'(fifo_empty), 1);
    chk("t6_valid", int'(rd_valid), 0);
    chk("t6_dout",  int'(dout), 0);
    chk("t6_gray",  int'(rd_ptr_gray), 0);
    chk("t6_count", int'(rd_count), 0);
    chk("t6_addr",  int'(mem_rd_addr), 0);
    rd_en = 0;
    wr_gray = '0;
    step();
    step();
    rst_n = 1;
    for (int k = 0; k < 5; k++) step();
    chk("t6_empty_hold", int'(fifo_empty), 1);
    chk("t6_count_hold", int'(rd_count), 0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
